// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA responder block.
package dma_pkg;

  localparam int DATA_W_DEFAULT = 128;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    XFER,
    DONE
  } dma_state_t;

  // Width of a beat counter that must hold 0..burst_len inclusive.
  function automatic int beat_cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous valid/ready FIFO with registered show-ahead head and registered flags.
module dma_sync_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
  logic              push, pop;

  // A beat is only honoured when the registered flag allows it, so a refused
  // push or pop never moves a pointer.
  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign wr_nxt  = wr_ptr + {{AW{1'b0}}, push};
  assign rd_nxt  = rd_ptr + {{AW{1'b0}}, pop};
  assign cnt_nxt = wr_nxt - rd_nxt;

  // Storage array; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // Pointers, flags and head register all computed from next-state pointers
  // so every output is a flop. The head bypasses the array when the slot it
  // needs is being written on this same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      count     <= cnt_nxt;
      in_ready  <= (cnt_nxt != FULL_CNT);
      out_valid <= (cnt_nxt != '0);
      if (push && (rd_nxt == wr_ptr)) out_data <= in_data;
      else                            out_data <= mem[rd_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/dma_responder.sv
// Target side of the DMA req/resp handshake: offers a fixed burst once the
// local FIFOs can sustain it, then streams TX beats out and RX beats in.
module dma_responder
  import dma_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              dma_resp,
  input  logic              dma_req,
  output logic              dma_read_valid,
  output logic [DATA_W-1:0] dma_read_data,
  input  logic              dma_read_ready,
  input  logic              dma_write_valid,
  input  logic [DATA_W-1:0] dma_write_data,
  output logic              dma_write_ready,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              snk_valid,
  output logic [DATA_W-1:0] snk_data,
  input  logic              snk_ready,
  output logic              proto_err
);

  localparam int CW = beat_cnt_w(BURST_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BL_C    = BURST_LEN[CW-1:0];
  localparam logic [AW:0]   BL_F    = BURST_LEN[AW:0];
  localparam logic [AW:0]   DEPTH_F = FIFO_DEPTH[AW:0];

  dma_state_t  state;
  logic [CW-1:0] rd_cnt, wr_cnt, rd_cnt_nxt, wr_cnt_nxt;
  logic [AW:0]   tx_count, rx_count, rx_free, tx_cnt_nxt, rx_cnt_nxt;
  logic          tx_avail, rx_space;
  logic          rd_beat, wr_beat, tx_push, rx_pop;

  // The FIFO flags are redundant with the registered channel handshakes but
  // keep the FIFOs safe even if the two ever disagree.
  assign rd_beat = dma_read_valid && dma_read_ready && tx_avail;
  assign wr_beat = dma_write_valid && dma_write_ready && rx_space;
  assign tx_push = src_valid && src_ready;
  assign rx_pop  = snk_valid && snk_ready;

  assign tx_cnt_nxt = tx_count + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, rd_beat};
  assign rx_cnt_nxt = rx_count + {{AW{1'b0}}, wr_beat} - {{AW{1'b0}}, rx_pop};
  assign rx_free    = DEPTH_F - rx_count;

  assign rd_cnt_nxt = (rd_beat && rd_cnt != BL_C) ? rd_cnt + 1'b1 : rd_cnt;
  assign wr_cnt_nxt = (wr_beat && wr_cnt != BL_C) ? wr_cnt + 1'b1 : wr_cnt;

  dma_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (src_valid),
    .in_data   (src_data),
    .in_ready  (src_ready),
    .out_valid (tx_avail),
    .out_data  (dma_read_data),
    .out_ready (rd_beat),
    .count     (tx_count)
  );

  dma_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (wr_beat),
    .in_data   (dma_write_data),
    .in_ready  (rx_space),
    .out_valid (snk_valid),
    .out_data  (snk_data),
    .out_ready (snk_ready),
    .count     (rx_count)
  );

  // Session FSM; channel enables are registered from next-state counts so the
  // burst side sees clean flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      dma_resp        <= 1'b0;
      dma_read_valid  <= 1'b0;
      dma_write_ready <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_count >= BL_F && rx_free >= BL_F) begin
            state    <= OFFER;
            dma_resp <= 1'b1;
          end
        end
        OFFER: begin
          if (dma_req) begin
            state           <= XFER;
            dma_read_valid  <= (tx_cnt_nxt != '0);
            dma_write_ready <= (rx_cnt_nxt != DEPTH_F);
          end
        end
        XFER: begin
          if (!dma_req) begin
            proto_err       <= 1'b1;
            state           <= IDLE;
            dma_resp        <= 1'b0;
            dma_read_valid  <= 1'b0;
            dma_write_ready <= 1'b0;
            rd_cnt          <= '0;
            wr_cnt          <= '0;
          end else if (rd_cnt_nxt == BL_C && wr_cnt_nxt == BL_C) begin
            state           <= DONE;
            dma_resp        <= 1'b0;
            dma_read_valid  <= 1'b0;
            dma_write_ready <= 1'b0;
            rd_cnt          <= rd_cnt_nxt;
            wr_cnt          <= wr_cnt_nxt;
          end else begin
            rd_cnt          <= rd_cnt_nxt;
            wr_cnt          <= wr_cnt_nxt;
            dma_read_valid  <= (rd_cnt_nxt < BL_C) && (tx_cnt_nxt != '0);
            dma_write_ready <= (wr_cnt_nxt < BL_C) && (rx_cnt_nxt != DEPTH_F);
          end
        end
        DONE: begin
          if (!dma_req) begin
            state  <= IDLE;
            rd_cnt <= '0;
            wr_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
